// File: rtl/frame_pixel_scheduler.sv
// Frame pixel scheduler: issues raster coordinates round-robin to NUM_ENG iteration
// engines and retires their results in strict round-robin order into one output stage.
module frame_pixel_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int ITER_W  = 8
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_enable,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic [NUM_ENG-1:0]        o_eng_req_valid,
    input  logic [NUM_ENG-1:0]        i_eng_req_ready,
    output logic [9:0]                o_eng_req_x,
    output logic [8:0]                o_eng_req_y,
    input  logic [NUM_ENG-1:0]        i_eng_res_valid,
    input  logic [NUM_ENG*ITER_W-1:0] i_eng_res_iter,
    output logic [NUM_ENG-1:0]        o_eng_res_ready,
    output logic [7:0]                o_pix_r,
    output logic [7:0]                o_pix_g,
    output logic [7:0]                o_pix_b,
    output logic                      o_pix_sof,
    output logic                      o_pix_eol,
    output logic                      o_pix_valid,
    input  logic                      i_pix_ready
);

    localparam int         PTR_W  = $clog2(NUM_ENG);
    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clear;

    logic [PTR_W-1:0]   r_issue_ptr;
    logic [PTR_W-1:0]   r_retire_ptr;
    logic [NUM_ENG-1:0] r_outstanding;
    logic [9:0]         r_ix;
    logic [8:0]         r_iy;
    logic [9:0]         r_rx;
    logic [8:0]         r_ry;

    logic [7:0]         r_pix_r;
    logic [7:0]         r_pix_g;
    logic [7:0]         r_pix_b;
    logic               r_pix_sof;
    logic               r_pix_eol;
    logic               r_pix_last;
    logic               r_pix_valid;
    logic               r_frame_done;

    logic               w_iss_ok;
    logic               w_iss_hs;
    logic               w_iss_last;
    logic               w_ret_ok;
    logic               w_pix_hs;
    logic [ITER_W-1:0]  w_iter_sel;
    logic [7:0]         w_iter8;
    logic               w_in_set;
    logic [7:0]         w_col_r;
    logic [7:0]         w_col_g;
    logic [7:0]         w_col_b;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENG - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- state machine ----------------
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_iss_hs && w_iss_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_outstanding == '0) && !r_pix_valid) begin
                    if (i_enable) begin
                        w_state_nxt = S_RUN;
                        w_clear     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- issue / retire handshakes ----------------
    always_comb begin
        w_iss_ok        = (r_state == S_RUN) && !r_outstanding[r_issue_ptr];
        o_eng_req_valid = '0;
        if (w_iss_ok) begin
            o_eng_req_valid[r_issue_ptr] = 1'b1;
        end
        w_iss_hs   = w_iss_ok && i_eng_req_ready[r_issue_ptr];
        w_iss_last = (r_ix == X_LAST) && (r_iy == Y_LAST);
    end

    // Only the engine at retire_ptr may hand over a result; others wait even if valid.
    always_comb begin
        w_ret_ok = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                   r_outstanding[r_retire_ptr] &&
                   i_eng_res_valid[r_retire_ptr] &&
                   (!r_pix_valid || i_pix_ready);
        o_eng_res_ready = '0;
        if (w_ret_ok) begin
            o_eng_res_ready[r_retire_ptr] = 1'b1;
        end
        w_pix_hs = r_pix_valid && i_pix_ready;
    end

    // ---------------- colour map ----------------
    assign w_iter_sel = i_eng_res_iter[int'(r_retire_ptr) * ITER_W +: ITER_W];
    assign w_in_set   = &w_iter_sel;

    generate
        if (ITER_W >= 8) begin : g_iter_wide
            assign w_iter8 = w_iter_sel[7:0];
        end else begin : g_iter_narrow
            assign w_iter8 = {{(8 - ITER_W){1'b0}}, w_iter_sel};
        end
    endgenerate

    always_comb begin
        w_col_r = '0;
        w_col_g = '0;
        w_col_b = '0;
        if (!w_in_set) begin
            w_col_r = w_iter8;
            w_col_g = ~w_iter8;
            w_col_b = {w_iter8[3:0], w_iter8[7:4]};
        end
    end

    // ---------------- pointers, counters, in-flight tracking ----------------
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_issue_ptr   <= '0;
            r_retire_ptr  <= '0;
            r_outstanding <= '0;
            r_ix          <= '0;
            r_iy          <= '0;
            r_rx          <= '0;
            r_ry          <= '0;
        end else begin
            r_outstanding <= (r_outstanding | (o_eng_req_valid & i_eng_req_ready)) &
                             ~o_eng_res_ready;
            if (w_clear) begin
                r_issue_ptr  <= '0;
                r_retire_ptr <= '0;
                r_ix         <= '0;
                r_iy         <= '0;
                r_rx         <= '0;
                r_ry         <= '0;
            end else begin
                if (w_iss_hs) begin
                    r_issue_ptr <= f_next_ptr(r_issue_ptr);
                    if (r_ix == X_LAST) begin
                        r_ix <= '0;
                        r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 9'd1;
                    end else begin
                        r_ix <= r_ix + 10'd1;
                    end
                end
                if (w_ret_ok) begin
                    r_retire_ptr <= f_next_ptr(r_retire_ptr);
                    if (r_rx == X_LAST) begin
                        r_rx <= '0;
                        r_ry <= (r_ry == Y_LAST) ? '0 : r_ry + 9'd1;
                    end else begin
                        r_rx <= r_rx + 10'd1;
                    end
                end
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_pix_r      <= '0;
            r_pix_g      <= '0;
            r_pix_b      <= '0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_last   <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pix_hs && r_pix_last;
            if (w_ret_ok) begin
                r_pix_r     <= w_col_r;
                r_pix_g     <= w_col_g;
                r_pix_b     <= w_col_b;
                r_pix_sof   <= (r_rx == '0) && (r_ry == '0);
                r_pix_eol   <= (r_rx == X_LAST);
                r_pix_last  <= (r_rx == X_LAST) && (r_ry == Y_LAST);
                r_pix_valid <= 1'b1;
            end else if (w_pix_hs) begin
                r_pix_sof   <= 1'b0;
                r_pix_eol   <= 1'b0;
                r_pix_last  <= 1'b0;
                r_pix_valid <= 1'b0;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_eng_req_x  = r_ix;
    assign o_eng_req_y  = r_iy;
    assign o_pix_r      = r_pix_r;
    assign o_pix_g      = r_pix_g;
    assign o_pix_b      = r_pix_b;
    assign o_pix_sof    = r_pix_sof;
    assign o_pix_eol    = r_pix_eol;
    assign o_pix_valid  = r_pix_valid;

endmodule

// File: tb/tb_frame_pixel_scheduler.sv
// Directed bench for frame_pixel_scheduler: 2 engines, 4x2 frame, behavioural engines
// with per-engine latency; pixels captured at the packer port and compared to hand tables.
module tb_frame_pixel_scheduler;

    localparam int NE = 2;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int IW = 8;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              enable = 1'b0;
    logic              pix_ready = 1'b1;
    logic              busy;
    logic              frame_done;
    logic [NE-1:0]     req_valid;
    logic [NE-1:0]     req_ready;
    logic [9:0]        req_x;
    logic [8:0]        req_y;
    logic [NE-1:0]     res_valid;
    logic [NE*IW-1:0]  res_iter;
    logic [NE-1:0]     res_ready;
    logic [7:0]        pr;
    logic [7:0]        pg;
    logic [7:0]        pb;
    logic              sof;
    logic              eol;
    logic              pvalid;

    always #5 aclk = ~aclk;

    frame_pixel_scheduler #(
        .NUM_ENG (NE),
        .X_SIZE  (XS),
        .Y_SIZE  (YS),
        .ITER_W  (IW)
    ) dut (
        .i_aclk          (aclk),
        .i_areset        (areset),
        .i_enable        (enable),
        .o_busy          (busy),
        .o_frame_done    (frame_done),
        .o_eng_req_valid (req_valid),
        .i_eng_req_ready (req_ready),
        .o_eng_req_x     (req_x),
        .o_eng_req_y     (req_y),
        .i_eng_res_valid (res_valid),
        .i_eng_res_iter  (res_iter),
        .o_eng_res_ready (res_ready),
        .o_pix_r         (pr),
        .o_pix_g         (pg),
        .o_pix_b         (pb),
        .o_pix_sof       (sof),
        .o_pix_eol       (eol),
        .o_pix_valid     (pvalid),
        .i_pix_ready     (pix_ready)
    );

    // ---------------- engine model ----------------
    int          lat [NE];
    logic        it_mode;
    logic [7:0]  it_const;
    logic [NE-1:0] m_busy;
    logic [NE-1:0] m_rv;
    int          m_cnt [NE];
    logic [7:0]  m_it [NE];

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_busy <= '0;
            m_rv   <= '0;
            for (int e = 0; e < NE; e++) begin
                m_cnt[e] <= 0;
                m_it[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < NE; e++) begin
                if (m_rv[e]) begin
                    if (res_ready[e]) begin
                        m_rv[e]   <= 1'b0;
                        m_busy[e] <= 1'b0;
                    end
                end else if (m_busy[e]) begin
                    if (m_cnt[e] == 0) m_rv[e] <= 1'b1;
                    else m_cnt[e] <= m_cnt[e] - 1;
                end else if (req_valid[e]) begin
                    m_busy[e] <= 1'b1;
                    m_cnt[e]  <= lat[e] - 1;
                    m_it[e]   <= it_mode ? it_const : (8'(req_x) + 8'(req_y));
                end
            end
        end
    end

    assign req_ready = ~m_busy;
    assign res_valid = m_rv;
    assign res_iter  = {m_it[1], m_it[0]};

    // ---------------- packer-side monitor ----------------
    logic [7:0] cap_r [256];
    logic [7:0] cap_g [256];
    logic [7:0] cap_b [256];
    logic       cap_sof [256];
    logic       cap_eol [256];
    int         qn = 0;
    int         ndone = 0;
    int         exp_rp = 0;
    int         stab_err = 0;
    int         stall_n = 0;
    int         rdy_err = 0;
    int         rdy_hold_n = 0;
    int         hot_err = 0;
    logic       pv_stall = 1'b0;
    logic [25:0] pv_data = '0;

    always @(negedge aclk) begin
        if (areset) begin
            pv_stall <= 1'b0;
            exp_rp   <= 0;
        end else begin
            if (pv_stall && (!pvalid || ({pr, pg, pb, sof, eol} != pv_data)))
                stab_err <= stab_err + 1;
            pv_stall <= pvalid && !pix_ready;
            pv_data  <= {pr, pg, pb, sof, eol};
            if (pvalid && !pix_ready) stall_n <= stall_n + 1;
            if (pvalid && pix_ready && qn < 256) begin
                cap_r[qn]   <= pr;
                cap_g[qn]   <= pg;
                cap_b[qn]   <= pb;
                cap_sof[qn] <= sof;
                cap_eol[qn] <= eol;
                qn <= qn + 1;
            end
            if (frame_done) ndone <= ndone + 1;
            if ($countones(req_valid) > 1 || $countones(res_ready) > 1) hot_err <= hot_err + 1;
            if (exp_rp == 0 && res_valid[1]) begin
                rdy_hold_n <= rdy_hold_n + 1;
                if (res_ready[1]) rdy_err <= rdy_err + 1;
            end
            if (|(res_valid & res_ready)) exp_rp <= (exp_rp + 1) % NE;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // r for iter = x + y over the 4x2 raster
    function automatic logic [7:0] sum_tab(input int k);
        case (k)
            0: return 8'd0;  1: return 8'd1;  2: return 8'd2;  3: return 8'd3;
            4: return 8'd1;  5: return 8'd2;  6: return 8'd3;  default: return 8'd4;
        endcase
    endfunction

    task automatic verify(input string t, input int base, input int n, input bit cmode,
                          input logic [7:0] c);
        logic [7:0] it;
        logic [7:0] er;
        logic [7:0] eg;
        logic [7:0] eb;
        int kk;
        for (int k = 0; k < n; k++) begin
            kk = k % (XS * YS);
            it = cmode ? c : sum_tab(kk);
            if (it == 8'hFF) begin
                er = '0; eg = '0; eb = '0;
            end else begin
                er = it; eg = ~it; eb = {it[3:0], it[7:4]};
            end
            chk($sformatf("%s_px%0d_r", t, k), cap_r[base+k], er);
            chk($sformatf("%s_px%0d_g", t, k), cap_g[base+k], eg);
            chk($sformatf("%s_px%0d_b", t, k), cap_b[base+k], eb);
            chk($sformatf("%s_px%0d_sof", t, k), cap_sof[base+k], kk == 0);
            chk($sformatf("%s_px%0d_eol", t, k), cap_eol[base+k], (kk % XS) == XS - 1);
        end
    endtask

    function automatic logic bp_pat(input int c);
        return (c % 4 == 0) || (c % 4 == 3);
    endfunction

    task automatic run(input string t, input int drop_at, input int nfr, input bit bp);
        int base;
        int fd;
        int idle_n;
        bit seen;
        base   = qn;
        fd     = 0;
        idle_n = 0;
        seen   = 1'b0;
        enable = 1'b1;
        for (int cyc = 0; cyc < 3000 && fd < nfr; cyc++) begin
            @(posedge aclk); #1;
            if (frame_done) fd++;
            if (busy) seen = 1'b1;
            else if (seen && fd < nfr) idle_n++;
            if ((qn - base) >= drop_at || fd >= nfr) enable = 1'b0;
            pix_ready = bp ? bp_pat(cyc) : 1'b1;
        end
        enable    = 1'b0;
        pix_ready = 1'b1;
        chk({t, "_frame_timeout"}, fd, nfr);
        chk({t, "_idle_gap"}, idle_n, 0);
    endtask

    task automatic settle(input string t, input int base, input int d0, input int npx,
                          input int nfr);
        repeat (4) begin
            @(posedge aclk); #1;
        end
        chk({t, "_pix_count"}, qn - base, npx);
        chk({t, "_frame_done"}, ndone - d0, nfr);
        chk({t, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int b;
        int d0;
        int h0;
        int s0;
        int w;
        lat      = '{3, 3};
        it_mode  = 1'b0;
        it_const = '0;

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pix_valid", pvalid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_pix_r", pr, 0);
        chk("rst_sof_eol", {sof, eol}, 0);
        chk("rst_req_xy", {req_x, req_y}, 0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // single frame, fixed latency, enable dropped at pixel 3
        b = qn; d0 = ndone;
        run("t1", 3, 1, 1'b0);
        settle("t1", b, d0, 8, 1);
        verify("t1", b, 8, 1'b0, 8'h00);

        // slow engine 0, fast engine 1: order must hold
        lat = '{10, 1};
        b = qn; d0 = ndone; h0 = rdy_hold_n;
        run("t2", 1, 1, 1'b0);
        settle("t2", b, d0, 8, 1);
        verify("t2", b, 8, 1'b0, 8'h00);
        chk("t2_eng1_held", rdy_hold_n > h0, 1);

        // backpressure 1,0,0,1
        lat = '{3, 3};
        b = qn; d0 = ndone; s0 = stall_n;
        run("t3", 1, 1, 1'b1);
        settle("t3", b, d0, 8, 1);
        verify("t3", b, 8, 1'b0, 8'h00);
        chk("t3_stalls_seen", stall_n > s0, 1);

        // in-set and fixed colour
        it_mode = 1'b1; it_const = 8'hFF;
        b = qn; d0 = ndone;
        run("t4a", 1, 1, 1'b0);
        settle("t4a", b, d0, 8, 1);
        verify("t4a", b, 8, 1'b1, 8'hFF);
        chk("t4a_rgb_zero", {cap_r[b+1], cap_g[b+1], cap_b[b+1]}, 0);
        it_const = 8'h12;
        b = qn; d0 = ndone;
        run("t4b", 1, 1, 1'b0);
        settle("t4b", b, d0, 8, 1);
        verify("t4b", b, 8, 1'b1, 8'h12);
        chk("t4b_rgb", {cap_r[b+2], cap_g[b+2], cap_b[b+2]}, 32'h12ED21);
        it_mode = 1'b0;

        // back-to-back frames with enable held
        b = qn; d0 = ndone;
        run("t5", 1000, 2, 1'b0);
        settle("t5", b, d0, 16, 2);
        verify("t5", b, 16, 1'b0, 8'h00);

        // reset mid-frame at pixel 5
        b = qn;
        enable = 1'b1;
        w = 0;
        while ((qn - b) < 5 && w < 500) begin
            @(posedge aclk); #1;
            w++;
        end
        chk("t6_reach_px5", (qn - b) >= 5, 1);
        #3;
        areset = 1'b1;
        #1;
        chk("t6_async_valid", pvalid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_req", req_valid, 0);
        chk("t6_async_res_rdy", res_ready, 0);
        chk("t6_async_rgb", {pr, pg, pb, sof, eol}, 0);
        enable = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        b = qn; d0 = ndone;
        run("t6", 1, 1, 1'b0);
        settle("t6", b, d0, 8, 1);
        verify("t6", b, 8, 1'b0, 8'h00);

        chk("stall_stability", stab_err, 0);
        chk("eng1_ready_order", rdy_err, 0);
        chk("onehot_strobes", hot_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
